hankel_matrix_wr: RTL
=====================

// Module: hankel_matrix_wr
// PURPOSE
//  Writer-side counterpart of the Hankel reader: collects a vector of 2N-1 samples
//  from a stream and writes the full N x N Hankel matrix H[i][j] = v[i+j] to a
//  word-addressed memory, row-major, through a wr/waddr/wdata/mem_ready handshake.
//  Sits between a sample producer and the matrix RAM that the Hankel reader consumes.
// PARAMETERS
//  N     8   matrix order; vector length is 2N-1 (15 by default)
//  DW    16  sample and memory word width
//  AW    8   memory address width; N*N <= 2**AW required (elaboration check)
//  BASE  0   address of H[0][0]
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  start      in   1   one-cycle request to begin a load+write pass
//  din        in   DW  sample; captured when din_valid && din_ready
//  din_valid  in   1   producer has a sample on din
//  din_ready  out  1   block accepts samples (high only in LOAD)
//  wr         out  1   memory write request; waddr/wdata valid while high
//  waddr      out  AW  write address = BASE + i*N + j
//  wdata      out  DW  write data = v[i+j]
//  mem_ready  in   1   memory accepts the write this cycle (wr && mem_ready = transfer)
//  busy       out  1   high in LOAD and WRITE
//  done       out  1   one-cycle pulse after the last matrix word is accepted
// BEHAVIOUR
//  - Reset (async, rst_n low): state=IDLE; din_ready, wr, busy, done = 0; waddr, wdata,
//    sample count, i, j = 0; buffer contents don't-care. Reset mid-pass aborts, no resume.
//  - IDLE: start=1 -> LOAD next cycle (count=0). start outside IDLE ignored.
//  - LOAD: din_ready=1; each accepted sample stored at buf[count], count++.
//    After sample 2N-2 is accepted -> WRITE next cycle, i=j=0. din_valid=0 stalls freely.
//  - WRITE: wr=1, waddr=BASE+i*N+j, wdata=buf[i+j], all registered. First wr appears the
//    cycle after the last sample is accepted. On wr && mem_ready: j++; at j=N-1, j=0,i++.
//    Outputs hold stable while mem_ready=0. Transfer of (N-1,N-1) -> DONE, wr drops next cycle.
//  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE. start in DONE is ignored.
//  - Back-to-back writes at full rate when mem_ready stays high: N*N cycles for WRITE.
//  - Address arithmetic: i*N+j computed in AW bits; BASE+N*N-1 must not exceed 2**AW-1
//    (no wrap, checked at elaboration). Index i+j in clog2(2N-1) bits, max 2N-2.
//  - din_valid outside LOAD ignored; mem_ready outside WRITE ignored.
// STRUCTURE
//  - hankel_pkg: state encoding (IDLE, LOAD, WRITE, DONE), localparams VLEN=2N-1,
//    IW=$clog2(VLEN), CW=$clog2(N), MSIZE=N*N; shared with the Hankel reader.
//  - Sub-module hankel_vbuf: VLEN x DW register file, one write port (LOAD), one
//    combinational read port indexed by i+j; read data registered in the top into wdata.
//  - Top: FSM, sample counter, i/j counters, address/data output registers.
// TESTING
//  1 Reset, start, din=1..15 on consecutive cycles, mem_ready=1 -> 64 writes in 64
//    cycles; waddr 0..63; wdata at addr 9 (i=1,j=1) = 3, at addr 63 = 15; done once.
//  2 Same load, mem_ready toggling 1,0,1,0 -> waddr/wdata stable during 0 cycles;
//    64 transfers total, no duplicates or skips, done after last transfer.
//  3 din_valid gaps (valid every 3rd cycle) -> din_ready high throughout LOAD,
//    15 samples captured in order, first wr one cycle after the 15th acceptance.
//  4 start pulsed during LOAD and WRITE -> ignored; pass completes normally, one done.
//  5 rst_n low at 30th write -> all outputs 0 immediately; new start + load
//    restarts at waddr=BASE, i=j=0.
//  6 BASE=16, N=4 -> 16 writes to addr 16..31, wdata row 3 = v[3..6]; done pulse.

Source files
------------

// File: rtl/hankel_pkg.sv
// Shared definitions for the Hankel matrix writer and reader: state encoding and size helpers.
package hankel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } hk_state_e;

  // Default-order sizes; instances derive their own from N with the helpers below.
  localparam int N_DEF     = 8;
  localparam int VLEN_DEF  = 2 * N_DEF - 1;
  localparam int IW_DEF    = $clog2(VLEN_DEF);
  localparam int CW_DEF    = $clog2(N_DEF);
  localparam int MSIZE_DEF = N_DEF * N_DEF;

  function automatic int vlen_f(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int iw_f(input int n);
    return (2 * n - 1 > 1) ? $clog2(2 * n - 1) : 1;
  endfunction

  function automatic int cw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hankel_vbuf.sv
// Sample vector store: one write port filled during LOAD, one combinational read port.
module hankel_vbuf
  import hankel_pkg::*;
#(
  parameter int VLEN = VLEN_DEF,
  parameter int DW   = 16,
  parameter int IW   = IW_DEF
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [IW-1:0] widx_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [IW-1:0] ridx_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [VLEN];

  // Contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[widx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/hankel_matrix_wr.sv
// Collects 2N-1 samples and writes the N x N Hankel matrix H[i][j] = v[i+j] row-major to memory.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_LOAD  | accepting samples into the vector buffer
//   ST_WRITE | presenting one matrix word per cycle, advancing on mem_ready
//   ST_DONE  | single-cycle completion pulse
module hankel_matrix_wr
  import hankel_pkg::*;
#(
  parameter int N    = 8,
  parameter int DW   = 16,
  parameter int AW   = 8,
  parameter int BASE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          wr,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done
);

  localparam int VLEN = vlen_f(N);
  localparam int IW   = iw_f(N);
  localparam int CW   = cw_f(N);

  if (N < 2) begin : g_bad_n
    $error("hankel_matrix_wr: N must be at least 2");
  end
  if (BASE + N * N > (1 << AW)) begin : g_bad_base
    $error("hankel_matrix_wr: BASE + N*N exceeds the address space");
  end

  hk_state_e     state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] i_q, i_d, j_q, j_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [IW-1:0] ridx;
  logic [DW-1:0] rdata;
  logic [AW-1:0] addr_nxt;
  logic          accept;

  assign accept = (state_q == ST_LOAD) && din_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (din_valid) begin
          cnt_d = cnt_q + IW'(1);
          if (cnt_q == IW'(VLEN - 1)) begin
            state_d = ST_WRITE;
            cnt_d   = '0;
            i_d     = '0;
            j_d     = '0;
          end
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          if (j_q == CW'(N - 1)) begin
            j_d = '0;
            if (i_q == CW'(N - 1)) state_d = ST_DONE;
            else                   i_d     = i_q + CW'(1);
          end else begin
            j_d = j_q + CW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers are loaded from the next indices so the word for (i,j) is
  // on the bus in the same cycle the FSM sits at (i,j); a stall recomputes the same word.
  assign ridx     = IW'(i_d) + IW'(j_d);
  assign addr_nxt = AW'(BASE) + AW'(i_d) * AW'(N) + AW'(j_d);
  assign waddr_d  = (state_d == ST_WRITE) ? addr_nxt : waddr_q;
  assign wdata_d  = (state_d == ST_WRITE) ? rdata    : wdata_q;

  hankel_vbuf #(
    .VLEN (VLEN),
    .DW   (DW),
    .IW   (IW)
  ) u_vbuf (
    .clk     (clk),
    .we_i    (accept),
    .widx_i  (cnt_q),
    .wdata_i (din),
    .ridx_i  (ridx),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign din_ready = (state_q == ST_LOAD);
  assign wr        = (state_q == ST_WRITE);
  assign busy      = din_ready || wr;
  assign done      = (state_q == ST_DONE);
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;

endmodule
